// File: rtl/seq_shifter.sv
// seq_shifter
//   Sequential 32-bit barrel-shift replacement: applies one 1-bit shift step
//   per clock until the requested amount has been consumed.
//
//   Ports
//     clk     in   1   clock, all state changes on the rising edge
//     rst_n   in   1   synchronous active-low reset
//     start   in   1   request pulse, only sampled while idle
//     op      in   2   00 SLL, 01 SRL, 10 ROR, 11 SRA
//     num     in  32   operand, captured when start is accepted
//     shamt   in   5   shift amount 0..31, captured when start is accepted
//     busy    out  1   high while shifting
//     done    out  1   one-cycle completion pulse
//     result  out 32   working register; final value valid with done and
//                      held until the next accepted start
module seq_shifter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] num,
    input  logic [4:0]  shamt,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_ROR = 2'b10;
    localparam logic [1:0] OP_SRA = 2'b11;

    state_t      state_reg;
    logic [4:0]  cnt_reg;
    logic [1:0]  op_reg;
    logic [31:0] step_next;

    // One-position moves of the working register. The fill bit at the
    // vacated end is chosen per operation below.
    logic [30:0] down_bits;   // result[31:1], destined for bits [30:0]
    logic [31:1] up_bits;     // result[30:0], destined for bits [31:1]

    genvar gi;
    generate
        for (gi = 0; gi < 31; gi = gi + 1) begin : g_move
            assign down_bits[gi]  = result[gi+1];
            assign up_bits[gi+1]  = result[gi];
        end
    endgenerate

    // SRA takes its fill from the current MSB each step, so the original
    // sign is replicated no matter how many steps are taken.
    always_comb begin
        step_next = result;
        case (op_reg)
            OP_SLL:  step_next = {up_bits, 1'b0};
            OP_SRL:  step_next = {1'b0, down_bits};
            OP_ROR:  step_next = {result[0], down_bits};
            OP_SRA:  step_next = {result[31], down_bits};
            default: step_next = result;
        endcase
    end

    // busy/done are written alongside the state so they are pure
    // registered decodes of it, with no path from the inputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            result    <= 32'h0;
            cnt_reg   <= 5'd0;
            op_reg    <= 2'b00;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        result  <= num;
                        op_reg  <= op;
                        cnt_reg <= shamt;
                        if (shamt == 5'd0) begin
                            state_reg <= DONE;
                            done      <= 1'b1;
                        end else begin
                            state_reg <= SHIFT;
                            busy      <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    result  <= step_next;
                    cnt_reg <= cnt_reg - 5'd1;
                    // cnt==1 means this edge performs the last step.
                    if (cnt_reg == 5'd1) begin
                        state_reg <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    done      <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shifter.sv
module tb_seq_shifter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] num;
    logic [4:0]  shamt;
    logic        busy;
    logic        done;
    logic [31:0] result;

    seq_shifter dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .num    (num),
        .shamt  (shamt),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] num;
        logic [4:0]  shamt;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] exp_result;
        int          exp_lat;
        int          exp_busy;
    } sb_t;

    sb_t sb_q[$];
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference model built from native shift operators.
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] v, input logic [4:0] s);
        logic [5:0] inv;
        inv = 6'd32 - {1'b0, s};
        case (o)
            2'b00:   model = v << s;
            2'b01:   model = v >> s;
            2'b10:   model = (s == 5'd0) ? v : ((v >> s) | (v << inv));
            default: model = $unsigned($signed(v) >>> s);
        endcase
    endfunction

    // Entered at a negedge in an IDLE cycle; returns at a negedge in the
    // following IDLE cycle so a back-to-back start is possible.
    task automatic run_op(input vec_t v, input bit inject, input string tag);
        int  edges;
        int  busy_cnt;
        sb_t exp_e;
        sb_t got;
        op    = v.op;
        num   = v.num;
        shamt = v.shamt;
        start = 1'b1;
        sb_q.push_back('{v.exp, int'(v.shamt) + 1, int'(v.shamt)});
        @(negedge clk);
        // Disturb the operands after acceptance; must not matter.
        start    = 1'b0;
        num      = $urandom;
        op       = ~v.op;
        shamt    = 5'd7;
        edges    = 1;
        busy_cnt = 0;
        while (!done && edges < 40) begin
            if (busy) busy_cnt++;
            if (inject && edges == 2) begin
                start = 1'b1;
                num   = 32'h1234_5678;
                shamt = 5'd7;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            edges++;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout: no done within %0d edges", tag, edges);
            sb_q.delete();
            start = 1'b0;
            return;
        end
        // In DONE: a start here must also be ignored when injecting.
        start = inject;
        got   = '{result, edges, busy_cnt};
        exp_e = sb_q.pop_front();
        check({tag, " result"}, got.exp_result, exp_e.exp_result);
        check({tag, " latency"}, got.exp_lat, exp_e.exp_lat);
        check({tag, " busy_cycles"}, got.exp_busy, exp_e.exp_busy);
        @(negedge clk);
        start = 1'b0;
        check({tag, " done_1cyc"}, {31'd0, done}, 32'd0);
        check({tag, " hold"}, result, exp_e.exp_result);
        if (inject) begin
            // Next cycle would show busy if the start in DONE had been taken.
            @(negedge clk);
            check({tag, " no_requeue"}, {31'd0, busy | done}, 32'd0);
            check({tag, " hold2"}, result, exp_e.exp_result);
        end
    endtask

    initial begin
        vec_t v;
        int   quiet_done;
        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        num   = 32'h0;
        shamt = 5'd0;

        vecs.push_back('{2'b00, 32'h0000_0001, 5'd4,  32'h0000_0010});
        vecs.push_back('{2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001});
        vecs.push_back('{2'b11, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF});
        vecs.push_back('{2'b11, 32'h8000_00F0, 5'd4,  32'hF800_000F});
        vecs.push_back('{2'b10, 32'h0000_0001, 5'd1,  32'h8000_0000});
        vecs.push_back('{2'b00, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF});
        vecs.push_back('{2'b10, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF});
        vecs.push_back('{2'b11, 32'h7000_0000, 5'd3,  32'h0E00_0000});
        vecs.push_back('{2'b10, 32'h1234_5678, 5'd8,  32'h7812_3456});
        for (int i = 0; i < 4; i++) begin
            v.op    = 2'($urandom_range(0, 3));
            v.num   = $urandom;
            v.shamt = 5'($urandom_range(0, 31));
            v.exp   = model(v.op, v.num, v.shamt);
            vecs.push_back(v);
        end

        repeat (2) @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);
        rst_n = 1'b1;

        // Table, issued back to back.
        foreach (vecs[i]) begin
            $display("vec %0d op=%0d num=%h shamt=%0d exp=%h", i, vecs[i].op, vecs[i].num, vecs[i].shamt, vecs[i].exp);
            run_op(vecs[i], 1'b0, $sformatf("vec%0d", i));
        end

        // Start pulses mid-SHIFT and during DONE are ignored.
        v = '{2'b00, 32'h0000_0003, 5'd6, 32'h0000_00C0};
        $display("inject op=SLL num=%h shamt=%0d", v.num, v.shamt);
        run_op(v, 1'b1, "inject");

        // Reset at the 3rd shift edge (edge 4 counted from accept).
        op    = 2'b00;
        num   = 32'h0000_0001;
        shamt = 5'd10;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1;           // sampled on the reset edge, must be ignored
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        check("abort result", result, 32'd0);
        quiet_done = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done || busy) quiet_done++;
        end
        check("abort no_done", 32'(quiet_done), 32'd0);
        $display("reset-abort observed %0d stray busy/done cycles", quiet_done);

        // First edge after reset release accepts start.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        v = '{2'b01, 32'hF000_0000, 5'd2, 32'h3C00_0000};
        $display("post-reset op=SRL num=%h shamt=%0d", v.num, v.shamt);
        run_op(v, 1'b0, "post_reset");

        check("scoreboard empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

endmodule
